uart_tx_sequencer: RTL
======================

Name: uart_tx_sequencer

Overview:
Transmit-side controller for the UART. It accepts a byte from a requester over a valid/ready handshake and captures it into its own holding register. It then sequences the frame onto the serial line: start bit, data bits LSB-first, optional parity bit, stop bit(s), with bit timing from an internal baud counter. It sits between the host logic and the tx pin and replaces ad-hoc loading of the transmit data and shift registers.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..8; frame uses tx_data[DATA_BITS-1:0].
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-low reset.
tx_data  input  8  byte to send; sampled only on an accepted handshake.
tx_valid  input  1  requester has a byte.
tx_ready  output  1  registered; high only in IDLE.
tx  output  1  serial line; registered; idles high.
busy  output  1  registered; high in every state except IDLE.
tx_done  output  1  registered; one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, baud counter=0, bit index=0, holding and shift registers all ones. Reset mid-frame aborts the frame. tx returns high on that edge, the byte is dropped, and no tx_done is produced.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: at an edge in IDLE with tx_valid=1, the block latches tx_data into the holding/shift register, moves to START and clears the baud counter. Next cycle tx=0, tx_ready=0, busy=1.
- Bit timing: each state holds tx for exactly CLKS_PER_BIT cycles. The counter runs 0..CLKS_PER_BIT-1 and the state or bit advances on the edge where count=CLKS_PER_BIT-1; the counter then wraps to 0.
- START: tx=0. Advances to DATA with bit index 0.
- DATA: tx=shift[0]. At each bit boundary the register shifts right and the bit index increments. After bit DATA_BITS-1 the block goes to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: tx = XOR of the captured data bits, XORed with PARITY_ODD. Parity is computed from the held copy, never the live tx_data.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final edge: state=IDLE, tx_done=1 for one cycle, tx_ready=1, busy=0.
- Frame length from the accept edge to the IDLE return is (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back: with tx_valid held high, the next byte is accepted on the first IDLE edge. The line therefore has exactly one extra idle-high cycle between frames. tx_done and the next accept can occur in the same cycle.
- tx_valid and tx_data changes while busy=1 are ignored and have no effect on the frame in flight.
- Unused tx_data bits above DATA_BITS-1 are ignored.
- There are no combinational paths from inputs to outputs.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: hold reset=0 for 3 cycles, then release -> tx=1, tx_ready=1, busy=0, tx_done=0 indefinitely with tx_valid=0.
- Single byte 0xA5, CLKS_PER_BIT=4, 8N1: one-cycle tx_valid -> 40-cycle frame. tx sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1. tx_done pulses once at cycle 40 and tx_ready returns high.
- Parity, PARITY_EN=1: send 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0. Frame length is 44 cycles.
- Back-to-back 0x55 then 0x0F with tx_valid held high -> exactly one idle-high cycle between frames. Both frames decode correctly at the bench receiver model.
- Data stability: change tx_data to 0xFF and pulse tx_valid mid-frame while sending 0x00 -> the frame still carries 0x00 and no second frame starts.
- Reset mid-frame: assert reset during the DATA bit 3 slot -> tx=1 on the next edge, no tx_done, and tx_ready=1 after release. A new 0x3C then transmits cleanly.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
// Transmit-side UART controller. It takes one byte over a valid/ready
// handshake and keeps a private copy of it. It then drives the serial frame:
// a start bit, the data bits LSB-first, an optional parity bit, and one or
// two stop bits. An internal counter sets each bit to CLKS_PER_BIT clocks.
// Every output comes straight from a flop.
module uart_tx_sequencer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;      // clocks elapsed inside the current bit
    logic [2:0]       bit_idx_q;  // data bit index, reused as stop bit index
    logic [7:0]       hold_q;     // captured byte, kept intact for parity
    logic [7:0]       shift_q;    // copy of the byte, shifted out LSB-first
    logic             tx_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic [7:0]       data_mask;
    logic             bit_end;
    logic             parity_bit;

    // Bits above DATA_BITS-1 never reach the line, so they must not
    // contribute to parity either.
    for (genvar gi = 0; gi < 8; gi++) begin : g_data_mask
        assign data_mask[gi] = (gi < DATA_BITS);
    end

    assign bit_end    = (cnt_q == CNT_LAST);
    assign parity_bit = (^(hold_q & data_mask)) ^ (PARITY_ODD != 0);

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

    // Frame sequencer: state, bit timing, and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            hold_q    <= '1;
            shift_q   <= '1;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // The bit counter only runs while a frame is in flight.
            // It wraps at the end of every bit.
            if (state_q != ST_IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (tx_valid) begin
                        hold_q    <= tx_data;
                        shift_q   <= tx_data;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= ST_START;
                        tx_q      <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        shift_q <= {1'b1, shift_q[7:1]};
                        if (bit_idx_q == DATA_LAST) begin
                            bit_idx_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q <= ST_PARITY;
                                tx_q    <= parity_bit;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            // The next data bit is the one about to move into bit 0.
                            tx_q      <= shift_q[1];
                        end
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        state_q   <= ST_STOP;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b1;
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_idx_q == STOP_LAST) begin
                            state_q   <= ST_IDLE;
                            bit_idx_q <= '0;
                            done_q    <= 1'b1;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    tx_q      <= 1'b1;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule
